// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes RV32I ALU-class instructions into ALU select/operands and holds them for execute.
// Optional macro ALU_ISSUE_ILLEGAL_EN flags undefined OP/OP-IMM funct encodings as illegal.
module alu_issue_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [31:0]      id_instr,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic             flush,
   input  logic             ex_ready,
   output logic             ex_valid,
   output logic [3:0]       ex_alu_sel,
   output logic [XLEN-1:0]  ex_inp1,
   output logic [XLEN-1:0]  ex_inp2,
   output logic [4:0]       ex_rd,
   output logic             ex_reg_write,
   output logic             ex_is_alu,
   output logic             ex_illegal,
   output logic [CNT_W-1:0] issue_count
);

   localparam logic [3:0] SEL_ADD   = 4'd0;
   localparam logic [3:0] SEL_SUB   = 4'd1;
   localparam logic [3:0] SEL_SLL   = 4'd2;
   localparam logic [3:0] SEL_SLT   = 4'd3;
   localparam logic [3:0] SEL_SLTU  = 4'd4;
   localparam logic [3:0] SEL_XOR   = 4'd5;
   localparam logic [3:0] SEL_SRL   = 4'd6;
   localparam logic [3:0] SEL_SRA   = 4'd7;
   localparam logic [3:0] SEL_OR    = 4'd8;
   localparam logic [3:0] SEL_AND   = 4'd9;
   localparam logic [3:0] SEL_LUI   = 4'd10;
   localparam logic [3:0] SEL_AUIPC = 4'd11;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;

   assign opcode = id_instr[6:0];
   assign funct3 = id_instr[14:12];
   assign funct7 = id_instr[31:25];
   assign rd     = id_instr[11:7];

   // Immediates: I-type sign-extended, U-type upper 20 bits kept unshifted (ALU shifts by 12).
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_sh;

   assign imm_i[11:0]  = id_instr[31:20];
   assign imm_u[19:0]  = id_instr[31:12];
   assign imm_sh[4:0]  = id_instr[24:20];

   genvar gi;
   generate
      for (gi = 12; gi < XLEN; gi++) begin : g_imm_i_sext
         assign imm_i[gi] = id_instr[31];
      end
      for (gi = 20; gi < XLEN; gi++) begin : g_imm_u_zext
         assign imm_u[gi] = 1'b0;
      end
      for (gi = 5; gi < XLEN; gi++) begin : g_imm_sh_zext
         assign imm_sh[gi] = 1'b0;
      end
   endgenerate

   logic [3:0] base_sel;

   always_comb begin
      base_sel = SEL_ADD;
      case (funct3)
         3'b000:  base_sel = SEL_ADD;
         3'b001:  base_sel = SEL_SLL;
         3'b010:  base_sel = SEL_SLT;
         3'b011:  base_sel = SEL_SLTU;
         3'b100:  base_sel = SEL_XOR;
         3'b101:  base_sel = SEL_SRL;
         3'b110:  base_sel = SEL_OR;
         default: base_sel = SEL_AND;
      endcase
   end

`ifdef ALU_ISSUE_ILLEGAL_EN
   logic op_legal;
   logic opimm_legal;

   always_comb begin
      op_legal = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      opimm_legal = 1'b1;
      if (funct3 == 3'b001) begin
         opimm_legal = (funct7 == 7'b0000000);
      end else if (funct3 == 3'b101) begin
         opimm_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
   end
`endif

   logic [3:0]      sel_next;
   logic [XLEN-1:0] inp1_next;
   logic [XLEN-1:0] inp2_next;
   logic            is_alu_next;
   logic            illegal_next;
   logic            reg_write_next;

   always_comb begin
      sel_next     = SEL_ADD;
      inp1_next    = id_rs1_data;
      inp2_next    = id_rs2_data;
      is_alu_next  = 1'b0;
      illegal_next = 1'b0;
      case (opcode)
         OPC_OP: begin
            is_alu_next = 1'b1;
            sel_next    = base_sel;
            // funct7 bit 5 picks the alternate form of ADD and SRL.
            if (funct7[5] && (funct3 == 3'b000)) sel_next = SEL_SUB;
            if (funct7[5] && (funct3 == 3'b101)) sel_next = SEL_SRA;
`ifdef ALU_ISSUE_ILLEGAL_EN
            if (!op_legal) begin
               illegal_next = 1'b1;
               sel_next     = SEL_ADD;
            end
`endif
         end
         OPC_OPIMM: begin
            is_alu_next = 1'b1;
            sel_next    = base_sel;
            inp2_next   = imm_i;
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) inp2_next = imm_sh;
            if (funct7[5] && (funct3 == 3'b101)) sel_next = SEL_SRA;
`ifdef ALU_ISSUE_ILLEGAL_EN
            if (!opimm_legal) begin
               illegal_next = 1'b1;
               sel_next     = SEL_ADD;
            end
`endif
         end
         OPC_LUI: begin
            is_alu_next = 1'b1;
            sel_next    = SEL_LUI;
            inp1_next   = '0;
            inp2_next   = imm_u;
         end
         OPC_AUIPC: begin
            is_alu_next = 1'b1;
            sel_next    = SEL_AUIPC;
            inp1_next   = id_pc;
            inp2_next   = imm_u;
         end
         default: ;
      endcase
      reg_write_next = is_alu_next && !illegal_next && (rd != 5'd0);
   end

   logic             ex_valid_reg;
   logic [3:0]       ex_alu_sel_reg;
   logic [XLEN-1:0]  ex_inp1_reg;
   logic [XLEN-1:0]  ex_inp2_reg;
   logic [4:0]       ex_rd_reg;
   logic             ex_reg_write_reg;
   logic             ex_is_alu_reg;
   logic             ex_illegal_reg;
   logic [CNT_W-1:0] issue_count_reg;
   logic             transfer;

   assign id_ready = !ex_valid_reg || ex_ready;
   assign transfer = id_valid && id_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_reg     <= 1'b0;
         ex_alu_sel_reg   <= '0;
         ex_inp1_reg      <= '0;
         ex_inp2_reg      <= '0;
         ex_rd_reg        <= '0;
         ex_reg_write_reg <= 1'b0;
         ex_is_alu_reg    <= 1'b0;
         ex_illegal_reg   <= 1'b0;
         issue_count_reg  <= '0;
      end else if (flush) begin
         // Remaining fields are left stale; only the live/write qualifiers matter.
         ex_valid_reg     <= 1'b0;
         ex_reg_write_reg <= 1'b0;
      end else if (transfer) begin
         ex_valid_reg     <= 1'b1;
         ex_alu_sel_reg   <= sel_next;
         ex_inp1_reg      <= inp1_next;
         ex_inp2_reg      <= inp2_next;
         ex_rd_reg        <= rd;
         ex_reg_write_reg <= reg_write_next;
         ex_is_alu_reg    <= is_alu_next;
         ex_illegal_reg   <= illegal_next;
         issue_count_reg  <= issue_count_reg + 1'b1;
      end else if (ex_ready) begin
         ex_valid_reg     <= 1'b0;
      end
   end

   assign ex_valid     = ex_valid_reg;
   assign ex_alu_sel   = ex_alu_sel_reg;
   assign ex_inp1      = ex_inp1_reg;
   assign ex_inp2      = ex_inp2_reg;
   assign ex_rd        = ex_rd_reg;
   assign ex_reg_write = ex_reg_write_reg;
   assign ex_is_alu    = ex_is_alu_reg;
   assign ex_illegal   = ex_illegal_reg;
   assign issue_count  = issue_count_reg;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue register that drives the execute-stage ALU.
- Decodes RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC) into the 4-bit ALU select code and the two ALU operands, then registers them.
- Provides a valid/ready handshake toward decode and execute, a flush input for branch redirects, and an issued-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  decode holds an instruction
- id_ready  out  1  stage can accept this cycle
- id_instr  in  32  raw instruction
- id_pc  in  32  instruction PC
- id_rs1_data  in  32  rs1 register value
- id_rs2_data  in  32  rs2 register value
- flush  in  1  kill held and incoming instruction
- ex_ready  in  1  execute consumes ex_* this cycle
- ex_valid  out  1  ex_* outputs hold a live instruction
- ex_alu_sel  out  4  ALU select code
- ex_inp1  out  32  ALU operand 1
- ex_inp2  out  32  ALU operand 2
- ex_rd  out  5  destination register
- ex_reg_write  out  1  write rd at writeback
- ex_is_alu  out  1  opcode is ALU-class
- ex_illegal  out  1  ALU-class opcode with an undefined funct encoding
- issue_count  out  CNT_W  instructions accepted since reset

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Reset: every output register, including issue_count, goes to 0. id_ready is 1 in the first cycle after reset.
- Handshake:
  - id_ready = !ex_valid || ex_ready (combinational).
  - Transfer occurs when id_valid && id_ready && !flush; ex_* load on that clock edge, with 1-cycle latency.
  - When ex_valid && !ex_ready, all ex_* hold stable (stall).
  - If ex_ready is high and there is no transfer, ex_valid goes to 0.
- Flush priority: flush beats everything except rst.
  - Next cycle ex_valid = 0 and ex_reg_write = 0.
  - An incoming id instruction in the same cycle is discarded and not counted.
  - Other ex_* fields may keep stale values.
- Reset during a stall or flush: reset wins and all outputs clear.
- ALU select codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, LUI=10, AUIPC=11.
- OP (0110011):
  - funct7 = 0000000, by funct3 000..111: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 = 0100000: funct3 000 gives SUB, 101 gives SRA.
  - inp1 = rs1, inp2 = rs2.
- OP-IMM (0010011): same funct3 mapping; SUB is never produced.
  - inp2 is instr[31:20] sign-extended.
  - For funct3 001/101, inp2 = {27'b0, instr[24:20]}.
  - funct3 101 with instr[31:25] = 0100000 gives SRA, with 0000000 gives SRL.
  - funct3 001 requires instr[31:25] = 0.
- LUI (0110111): sel 10, inp1 = 0, inp2 = {12'b0, instr[31:12]}. The ALU applies the shift by 12.
- AUIPC (0010111): sel 11, inp1 = id_pc, inp2 = {12'b0, instr[31:12]}.
- Destination and write enable:
  - ex_rd = instr[11:7] for all opcodes.
  - ex_reg_write = ex_is_alu && !ex_illegal && rd != 0.
- Non-ALU opcodes: ex_is_alu = 0, sel 0, inp1 = rs1, inp2 = rs2, ex_reg_write = 0, ex_illegal = 0.
- issue_count: +1 on each transfer; wraps from all-ones to 0.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_EN.
- Defined: an undefined funct7/funct3 combination within OP or OP-IMM sets ex_illegal = 1, sel 0, ex_reg_write = 0.
- Not defined: ex_illegal is tied to 0. Undefined combinations decode by funct3 alone, with funct7 bit 5 selecting SUB/SRA, and write rd normally.

Test Plan:
- Reset sequence:
  - Stimulus: rst high for 2 cycles, then id_valid = 1 with instr 0x002081B3 (add x3,x1,x2), rs1 = 5, rs2 = 7.
  - Required: next cycle ex_valid = 1, sel 0, inp1 = 5, inp2 = 7, ex_rd = 3, ex_reg_write = 1, issue_count = 1.
- SRAI and LUI back to back:
  - Stimulus: instr 0x4040D193 (srai x3,x1,4), then 0x123452B7 (lui x5,0x12345).
  - Required: first sel 7, inp2 = 4; second sel 10, inp1 = 0, inp2 = 0x00012345.
- Stall:
  - Stimulus: ex_ready = 0 for 3 cycles with ex_valid = 1.
  - Required: id_ready = 0 and ex_* stable for all 3 cycles. When ex_ready returns to 1, the pending instruction loads the following cycle.
- Flush during stall:
  - Stimulus: flush = 1 while ex_valid = 1, ex_ready = 0, id_valid = 1.
  - Required: next cycle ex_valid = 0 and issue_count unchanged.
- Destination x0:
  - Stimulus: instr 0x00500013 (addi x0,x0,5).
  - Required: sel 0, inp2 = 5, ex_reg_write = 0.
- Illegal encoding (macro defined):
  - Stimulus: instr 0x402091B3 (funct7 0100000, funct3 001).
  - Required: ex_illegal = 1, ex_reg_write = 0.
